// File: rtl/conv1x1_scheduler.sv
`default_nettype none
// conv1x1_scheduler: (pixel, oc) issue sequencer, MACC strobe alignment, credited result FIFO.
// Optional ReLU at FIFO push when CONV1X1_SCHED_RELU_EN is defined.
module conv1x1_scheduler #(
  parameter int DATA_WIDTH   = 8,
  parameter int ACC_WIDTH    = 20,
  parameter int IN_WIDTH     = 28,
  parameter int IN_HEIGHT    = 28,
  parameter int OUT_CHANNELS = 32,
  parameter int RD_LATENCY   = 2,
  parameter int FIFO_DEPTH   = 8,
  localparam int NUM_PIX     = IN_WIDTH * IN_HEIGHT,
  localparam int TOTAL       = NUM_PIX * OUT_CHANNELS,
  localparam int PIX_W       = (NUM_PIX > 1) ? $clog2(NUM_PIX) : 1,
  localparam int OC_W        = (OUT_CHANNELS > 1) ? $clog2(OUT_CHANNELS) : 1,
  localparam int ADDR_W      = (TOTAL > 1) ? $clog2(TOTAL) : 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  output logic                  busy,
  output logic                  done,
  output logic                  in_rd_en,
  output logic [PIX_W-1:0]      in_rd_addr,
  output logic                  wt_rd_en,
  output logic [OC_W-1:0]       wt_rd_addr,
  output logic                  macc_i_valid,
  input  logic                  macc_o_valid,
  input  logic [ACC_WIDTH-1:0]  macc_o_data,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic [ADDR_W-1:0]     out_addr,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  err_overflow
);

  localparam int CRED_W = $clog2(FIFO_DEPTH + 1);
  localparam int PTR_W  = $clog2(FIFO_DEPTH);
  localparam int CNT_W  = $clog2(TOTAL + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t                  state, state_nxt;
  logic [CRED_W-1:0]       credits, credits_nxt;
  logic [CRED_W-1:0]       fill, fill_nxt;
  logic [CNT_W-1:0]        pop_count;
  logic [PIX_W-1:0]        pix;
  logic [OC_W-1:0]         oc;
  logic [RD_LATENCY-1:0]   lat_sr;
  logic [DATA_WIDTH-1:0]   mem [FIFO_DEPTH];
  logic [PTR_W-1:0]        wr_ptr, rd_ptr;
  logic [DATA_WIDTH-1:0]   push_val;
  logic                    issue_nxt, busy_nxt, done_nxt;
  logic                    last_pair, pop, fifo_full, push_ok, valid_q;
  logic                    unused_lsbs;

  assign last_pair = in_rd_en && (pix == PIX_W'(NUM_PIX - 1)) && (oc == OC_W'(OUT_CHANNELS - 1));
  assign pop       = valid_q && out_ready;
  assign fifo_full = (fill == CRED_W'(FIFO_DEPTH));
  assign push_ok   = macc_o_valid && !fifo_full;

`ifdef CONV1X1_SCHED_RELU_EN
  assign push_val = macc_o_data[ACC_WIDTH-1] ? '0 : macc_o_data[ACC_WIDTH-1 -: DATA_WIDTH];
`else
  assign push_val = macc_o_data[ACC_WIDTH-1 -: DATA_WIDTH];
`endif
  assign unused_lsbs = ^macc_o_data[ACC_WIDTH-DATA_WIDTH-1:0];

  always_comb begin
    state_nxt   = state;
    credits_nxt = credits;
    fill_nxt    = fill;
    case (state)
      IDLE:  if (start) state_nxt = ISSUE;
      ISSUE: if (last_pair) state_nxt = DRAIN;
      DRAIN: if ((pop_count == CNT_W'(TOTAL)) || (pop && (pop_count == CNT_W'(TOTAL - 1))))
               state_nxt = DONE;
      DONE:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    if (in_rd_en && !pop)
      credits_nxt = credits + CRED_W'(1);
    else if (!in_rd_en && pop)
      credits_nxt = credits - CRED_W'(1);
    if (state == IDLE && start)
      credits_nxt = '0;
    if (push_ok && !pop)
      fill_nxt = fill + CRED_W'(1);
    else if (!push_ok && pop)
      fill_nxt = fill - CRED_W'(1);
    // Issue is registered: decide next cycle's issue from next-cycle state and credits.
    issue_nxt = (state_nxt == ISSUE) && (credits_nxt < CRED_W'(FIFO_DEPTH));
    busy_nxt  = (state_nxt == ISSUE) || (state_nxt == DRAIN);
    done_nxt  = (state_nxt == DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      credits      <= '0;
      fill         <= '0;
      pop_count    <= '0;
      pix          <= '0;
      oc           <= '0;
      in_rd_en     <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
      lat_sr       <= '0;
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      valid_q      <= 1'b0;
      err_overflow <= 1'b0;
      for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
    end else begin
      state    <= state_nxt;
      credits  <= credits_nxt;
      fill     <= fill_nxt;
      in_rd_en <= issue_nxt;
      busy     <= busy_nxt;
      done     <= done_nxt;
      valid_q  <= (fill_nxt != '0);

      if (state == IDLE && start) begin
        pix       <= '0;
        oc        <= '0;
        pop_count <= '0;
      end else begin
        if (in_rd_en) begin
          if (oc == OC_W'(OUT_CHANNELS - 1)) begin
            oc  <= '0;
            pix <= (pix == PIX_W'(NUM_PIX - 1)) ? '0 : pix + PIX_W'(1);
          end else begin
            oc <= oc + OC_W'(1);
          end
        end
        if (pop) pop_count <= pop_count + CNT_W'(1);
      end

      lat_sr[0] <= in_rd_en;
      for (int i = 1; i < RD_LATENCY; i++) lat_sr[i] <= lat_sr[i-1];

      if (push_ok) begin
        mem[wr_ptr] <= push_val;
        wr_ptr      <= wr_ptr + PTR_W'(1);
      end
      if (macc_o_valid && fifo_full) err_overflow <= 1'b1;
      if (pop) rd_ptr <= rd_ptr + PTR_W'(1);
    end
  end

  assign wt_rd_en     = in_rd_en;
  assign in_rd_addr   = pix;
  assign wt_rd_addr   = oc;
  assign macc_i_valid = lat_sr[RD_LATENCY-1];
  assign out_valid    = valid_q;
  assign out_data     = mem[rd_ptr];
  assign out_addr     = pop_count[ADDR_W-1:0];

endmodule
`default_nettype wire

// File: tb/tb_conv1x1_scheduler.sv
`default_nettype none
// tb_conv1x1_scheduler: randomized passes checked against a pass-level result model
// with a fixed-latency MACC/buffer stand-in.
module tb_conv1x1_scheduler;
  localparam int DW = 8, AW = 20, W = 2, H = 2, OC = 4, RL = 2, FD = 4;
  localparam int TOT = W * H * OC, MACC_LAT = 3;

  logic          clk = 1'b0, rst = 1'b1, start = 1'b0;
  logic          busy, done, in_rd_en, wt_rd_en, macc_i_valid, out_valid, err_overflow;
  logic [1:0]    in_rd_addr, wt_rd_addr;
  logic [3:0]    out_addr;
  logic [DW-1:0] out_data;
  logic          macc_o_valid, out_ready;
  logic [AW-1:0] macc_o_data;

  conv1x1_scheduler #(
    .DATA_WIDTH(DW), .ACC_WIDTH(AW), .IN_WIDTH(W), .IN_HEIGHT(H),
    .OUT_CHANNELS(OC), .RD_LATENCY(RL), .FIFO_DEPTH(FD)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
    .in_rd_en(in_rd_en), .in_rd_addr(in_rd_addr), .wt_rd_en(wt_rd_en), .wt_rd_addr(wt_rd_addr),
    .macc_i_valid(macc_i_valid), .macc_o_valid(macc_o_valid), .macc_o_data(macc_o_data),
    .out_data(out_data), .out_addr(out_addr), .out_valid(out_valid), .out_ready(out_ready),
    .err_overflow(err_overflow)
  );

  always #5 clk = ~clk;

  int total = 0, bad = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [DW-1:0] quant(input logic [AW-1:0] acc);
`ifdef CONV1X1_SCHED_RELU_EN
    if (acc >= 20'h80000) return '0;
`endif
    return DW'(acc / (1 << (AW - DW)));
  endfunction

  // Shared state: main writes acc_tab/rdy_mode/start/rst; the monitor owns everything else.
  logic [AW-1:0] acc_tab [TOT];
  int rdy_mode = 0;
  int cyc = 0, n_issue = 0, done_cnt = 0, last_pop = -10;
  int iss_cyc[$], iss_idx[$], exp_addr[$], exp_data[$];
  bit sv [8];
  logic [AW-1:0] sd [8];
  bit hold_prev = 0;
  logic [12:0] prev_vec;

  initial begin
    int c, idx;
    out_ready = 1'b0; macc_o_valid = 1'b0; macc_o_data = '0;
    forever begin
      @(negedge clk);
      cyc++;
      if (rst) begin
        iss_cyc.delete(); iss_idx.delete(); exp_addr.delete(); exp_data.delete();
        for (int i = 0; i < 8; i++) sv[i] = 0;
        n_issue = 0; hold_prev = 0;
        macc_o_valid = 1'b0; out_ready = 1'b0;
        continue;
      end
      if (start && !busy && !done) begin
        n_issue = 0; done_cnt = 0;
        iss_cyc.delete(); iss_idx.delete(); exp_addr.delete(); exp_data.delete();
        for (int i = 0; i < TOT; i++) begin
          exp_addr.push_back(i);
          exp_data.push_back(int'(quant(acc_tab[i])));
        end
      end
      if (in_rd_en) begin
        check_eq("extra_issue", n_issue < TOT, 1);
        check_eq("iss_addr", {in_rd_addr, wt_rd_addr}, ((n_issue / OC) << 2) | (n_issue % OC));
        check_eq("wt_en", wt_rd_en, 1);
        iss_cyc.push_back(cyc); iss_idx.push_back(n_issue);
        n_issue++;
      end
      if (macc_i_valid) begin
        if (iss_cyc.size() == 0) check_eq("spur_ivalid", macc_i_valid, 0);
        else begin
          c = iss_cyc.pop_front(); idx = iss_idx.pop_front();
          check_eq("align", cyc - c, RL);
          sv[(cyc + MACC_LAT) % 8] = 1;
          sd[(cyc + MACC_LAT) % 8] = acc_tab[idx % TOT];
        end
      end
      macc_o_valid = sv[cyc % 8];
      macc_o_data  = sd[cyc % 8];
      sv[cyc % 8]  = 0;
      case (rdy_mode)
        0:       out_ready = 1'b1;
        1:       out_ready = 1'b0;
        default: out_ready = ($urandom % 4) != 0;
      endcase
      if (hold_prev) check_eq("hold", {out_valid, out_addr, out_data}, prev_vec);
      hold_prev = out_valid && !out_ready;
      prev_vec  = {out_valid, out_addr, out_data};
      if (out_valid && out_ready) begin
        if (exp_addr.size() == 0) check_eq("extra_pop", out_valid, 0);
        else begin
          check_eq("out_addr", out_addr, exp_addr.pop_front());
          check_eq("out_data", out_data, exp_data.pop_front());
        end
        last_pop = cyc;
      end
      if (done) begin
        done_cnt++;
        check_eq("done_busy", busy, 0);
        check_eq("done_lat", cyc - last_pop, 1);
        check_eq("done_left", exp_addr.size(), 0);
      end
    end
  end

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic pulse_start();
    @(posedge clk); #2 start = 1'b1;
    @(posedge clk); #2 start = 1'b0;
  endtask

  task automatic fill_tab();
    for (int i = 0; i < TOT; i++) acc_tab[i] = AW'($urandom);
  endtask

  task automatic check_zero(input string tag);
    check_eq({tag, "_ctrl"}, {busy, done, in_rd_en, wt_rd_en, macc_i_valid, out_valid, err_overflow}, 0);
    check_eq({tag, "_addr"}, {in_rd_addr, wt_rd_addr, out_addr}, 0);
    check_eq({tag, "_data"}, out_data, 0);
  endtask

  task automatic wait_done(input string tag);
    for (int i = 0; i < 400 && done_cnt == 0; i++) begin
      @(posedge clk); #2;
    end
    check_eq({tag, "_done_seen"}, done_cnt, 1);
    wait_cyc(6);
    check_eq({tag, "_done_once"}, done_cnt, 1);
    check_eq({tag, "_issues"}, n_issue, TOT);
    check_eq({tag, "_left"}, exp_addr.size(), 0);
    check_eq({tag, "_ovf"}, err_overflow, 0);
  endtask

  initial begin
    int cnt;
    for (int i = 0; i < TOT; i++) acc_tab[i] = '0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_zero("reset");
    @(posedge clk); #2 rst = 1'b0;
    wait_cyc(2);

    // Basic pass, sink always ready; includes the quantisation corner values.
    fill_tab();
    acc_tab[0] = 20'hFFFF0;
    acc_tab[1] = 20'h12345;
    rdy_mode = 0;
    pulse_start();
    wait_done("basic");

    // Backpressure: sink stalled for 20 cycles, issue must stop at FIFO_DEPTH.
    fill_tab();
    rdy_mode = 1;
    pulse_start();
    wait_cyc(20);
    check_eq("bp_issues", n_issue, FD);
    check_eq("bp_rd_en", in_rd_en, 0);
    check_eq("bp_ovf", err_overflow, 0);
    rdy_mode = 0;
    wait_done("bp");

    // start pulses during ISSUE and DRAIN are ignored.
    fill_tab();
    rdy_mode = 2;
    pulse_start();
    wait_cyc(3);
    pulse_start();
    for (int i = 0; i < 300 && n_issue < TOT; i++) begin
      @(posedge clk); #2;
    end
    check_eq("issue_all", n_issue, TOT);
    check_eq("drain_state", {busy, in_rd_en}, 2'b10);
    pulse_start();
    wait_done("glitch");

    // Reset during the 7th issue cycle.
    fill_tab();
    rdy_mode = 0;
    pulse_start();
    cnt = 0;
    for (int i = 0; i < 100; i++) begin
      if (in_rd_en) cnt++;
      if (cnt == 7) break;
      @(posedge clk); #2;
    end
    check_eq("rst_point", cnt, 7);
    rst = 1'b1;
    @(posedge clk); #2 rst = 1'b0;
    @(negedge clk);
    check_zero("mid_rst");
    wait_cyc(30);
    check_eq("rst_no_done", done_cnt, 0);
    check_eq("rst_idle", {busy, out_valid}, 0);

    fill_tab();
    rdy_mode = 2;
    pulse_start();
    wait_done("after_rst");

    fill_tab();
    rdy_mode = 0;
    pulse_start();
    wait_done("final");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/conv1x1_scheduler.md
# conv1x1_scheduler

Sequencing controller for the pointwise (1x1) convolution datapath. Walks every (pixel, output-channel) pair and drives read enables and addresses into the input and weight buffers. Generates the MACC `i_valid` strobe aligned to buffer read latency, and captures MACC results into a small result FIFO. The FIFO drains through a valid/ready output port with linear output addresses; a credit counter throttles issue so the downstream sink can stall without losing results.

## Interface
- `DATA_WIDTH`, 8: output element width.
- `ACC_WIDTH`, 20: MACC result width.
- `IN_WIDTH`, 28 / `IN_HEIGHT`, 28: feature-map size; `NUM_PIX = IN_WIDTH*IN_HEIGHT`.
- `OUT_CHANNELS`, 32: output channels; `TOTAL = NUM_PIX*OUT_CHANNELS`.
- `RD_LATENCY`, 2: buffer read latency in cycles, from rd_en to data (1..4).
- `FIFO_DEPTH`, 8: result FIFO depth (power of two, ≥2).
- `clk`  in  1  clock, all logic rising-edge.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  begin a layer pass; sampled only in IDLE.
- `busy`  out  1  high in ISSUE and DRAIN.
- `done`  out  1  one-cycle pulse at end of pass.
- `in_rd_en`  out  1  input buffer read enable.
- `in_rd_addr`  out  clog2(NUM_PIX)  pixel index.
- `wt_rd_en`  out  1  weight buffer read enable (equals `in_rd_en`).
- `wt_rd_addr`  out  clog2(OUT_CHANNELS)  output-channel index.
- `macc_i_valid`  out  1  MACC operand-valid strobe.
- `macc_o_valid`  in  1  MACC result valid.
- `macc_o_data`  in  ACC_WIDTH  MACC result.
- `out_data`  out  DATA_WIDTH  quantised result.
- `out_addr`  out  clog2(TOTAL)  linear address `pixel*OUT_CHANNELS + oc`.
- `out_valid`  out  1  result available.
- `out_ready`  in  1  sink accepts.
- `err_overflow`  out  1  sticky: result arrived with FIFO full.

## Operation
- FSM states: IDLE, ISSUE, DRAIN, DONE.
  - IDLE: on `start` clear counters and go to ISSUE.
  - ISSUE: go to DRAIN after the issue of pair `TOTAL-1`.
  - DRAIN: go to DONE when `pop_count == TOTAL`.
  - DONE: one cycle, then IDLE.
- `start` is ignored outside IDLE.
- Issue order: `oc` is the inner loop (0..OUT_CHANNELS-1) and `pixel` the outer loop. At wrap, `oc` returns to 0 and `pixel` increments.
- Issue condition: state ISSUE and `credits < FIFO_DEPTH`.
  - `credits` = issued minus popped.
  - Increments on issue, decrements on pop; both in the same cycle leaves it unchanged.
- `macc_i_valid` = issue strobe delayed by exactly RD_LATENCY cycles through a shift register. The shift register is cleared by reset.
- Results are pushed into the FIFO on `macc_o_valid`, in order.
- `err_overflow` sets if a push occurs while the FIFO is full. The push is dropped and the flag clears only on reset. The credit scheme makes this unreachable in legal operation.
- Pop on `out_valid && out_ready`. `out_addr` = `pop_count`, which starts at 0 per pass.
- Quantisation: `out_data = acc[ACC_WIDTH-1 -: DATA_WIDTH]`.
- Reset mid-pass: return to IDLE, flush FIFO, zero all counters and credits, clear the shift register. Any late `macc_o_valid` after reset is pushed into the empty FIFO; the integrator must reset the MACC together with this block.

## Timing
- Reset values:
  - `busy`, `done`, `in_rd_en`, `wt_rd_en`, `macc_i_valid`, `out_valid`, `err_overflow` = 0.
  - `in_rd_addr`, `wt_rd_addr`, `out_addr`, `out_data` = 0.
- All outputs are registered.
- `start` sampled at edge N puts the block in ISSUE at N+1; first `in_rd_en` is at N+1.
- Issue at cycle t: `in_rd_en`, `wt_rd_en` and the addresses are valid in cycle t. `macc_i_valid` is high at t+RD_LATENCY.
- Push at cycle t: `out_valid` is high from t+1. Push and pop may occur in the same cycle.
- With `out_ready` held high and no MACC stalls:
  - one issue per cycle;
  - one pop per cycle after pipeline fill.
- `out_valid`/`out_data`/`out_addr` hold stable while `out_valid && !out_ready`.
- `done` is high for exactly one cycle, the cycle after the final pop; `busy` is low in that cycle.

## Configuration
- `CONV1X1_SCHED_RELU_EN` defined: if `acc[ACC_WIDTH-1]` is 1 (negative), `out_data` = 0; otherwise use the normal slice. Applied at FIFO push.
- Not defined: plain slice only, no ReLU logic synthesised.

## Test plan
- Config W=H=2, OUT_CHANNELS=4, RD_LATENCY=2, FIFO_DEPTH=4, MACC model with fixed 3-cycle latency.
- Basic pass, `out_ready`=1: expect 16 results with `out_addr` 0..15 in order. Issue addresses are (pix0,oc0..3) through (pix3,oc0..3). `done` pulses once; total ≤ 16+2+3+4 cycles.
- Backpressure, `out_ready`=0 for 20 cycles after `start`: exactly 4 issues, then `in_rd_en` stays low. `err_overflow` stays 0. On release all 16 results arrive in order.
- Alignment: each `macc_i_valid` occurs exactly 2 cycles after the matching `in_rd_en`, checked for every issue.
- Reset at the 7th issue cycle: all outputs are 0 next cycle and no `done`. A following `start` produces a full 16-result pass starting at `out_addr` 0.
- `start` pulsed during ISSUE and DRAIN: ignored; exactly one `done`.
- `CONV1X1_SCHED_RELU_EN`: MACC result 0xFFFF0 gives `out_data` 0x00; 0x12345 gives 0x12. Without the macro, 0xFFFF0 gives 0xFF.
